// File: rtl/ctl_seq.sv
// Control sequencer for the accumulator core: fetch/decode/execute FSM driving the
// address unit, IR, accumulator and ALU, with a req/ack memory handshake and ack watchdog.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RESET     | post-reset idle, all controls low, MAR source = PC
// FETCH_ADR | MAR <= PC
// FETCH     | read instruction at MAR; on ack load IR and PC <= MAR+1
// DECODE    | latch opcode, set up operand address or branch target
// EXEC_RD   | operand read; on ack load accumulator from the ALU
// EXEC_WR   | accumulator store to MAR
// HALT      | stopped until reset (HLT or watchdog expiry)
module ctl_seq #(
    parameter  int ACK_TIMEOUT      = 16,
    localparam int CTR_MARMUX_WIDTH = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [3:0]                  opcode_i,
    input  logic                        acc_zero_i,
    input  logic                        mem_ack_i,
    output logic [CTR_MARMUX_WIDTH-1:0] ctr_marmux_o,
    output logic                        ctr_mar_reg_en_o,
    output logic                        ctr_pc_reg_en_o,
    output logic                        ctr_ir_reg_en_o,
    output logic                        ctr_acc_reg_en_o,
    output logic [1:0]                  ctr_alu_op_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic                        halted_o,
    output logic                        bus_err_o
);

    localparam logic [CTR_MARMUX_WIDTH-1:0] MAR_OP_PC  = 1'b0;
    localparam logic [CTR_MARMUX_WIDTH-1:0] MAR_OP_ARG = 1'b1;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int             WD_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_INIT = WD_W'(ACK_TIMEOUT);
    localparam logic           WD_ON   = (ACK_TIMEOUT > 0);

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH_ADR,
        S_FETCH,
        S_DECODE,
        S_EXEC_RD,
        S_EXEC_WR,
        S_HALT
    } state_t;

    state_t          state_q, state_nxt;
    logic [3:0]      op_q;
    logic [WD_W-1:0] wd_cnt_q;
    logic            bus_err_q;
    logic            req_state;
    logic            req_wait;
    logic            wd_expire;

    // Request is a pure function of state, which keeps the watchdog free of output feedback.
    assign req_state = (state_q == S_FETCH) || (state_q == S_EXEC_RD) || (state_q == S_EXEC_WR);
    assign req_wait  = req_state && !mem_ack_i;
    assign wd_expire = WD_ON && req_wait && (wd_cnt_q == '0);
    assign bus_err_o = bus_err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_RESET;
            op_q      <= '0;
            wd_cnt_q  <= WD_INIT;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (state_q == S_DECODE) begin
                op_q <= opcode_i;
            end
            // Down-counter reloads whenever the request is idle or acknowledged.
            if (!req_wait) begin
                wd_cnt_q <= WD_INIT;
            end else if (wd_cnt_q != '0) begin
                wd_cnt_q <= wd_cnt_q - 1'b1;
            end
            if (wd_expire) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt        = state_q;
        ctr_marmux_o     = MAR_OP_PC;
        ctr_mar_reg_en_o = 1'b0;
        ctr_pc_reg_en_o  = 1'b0;
        ctr_ir_reg_en_o  = 1'b0;
        ctr_acc_reg_en_o = 1'b0;
        ctr_alu_op_o     = 2'd0;
        mem_req_o        = 1'b0;
        mem_we_o         = 1'b0;
        halted_o         = 1'b0;
        case (state_q)
            S_RESET: begin
                state_nxt = S_FETCH_ADR;
            end
            S_FETCH_ADR: begin
                ctr_mar_reg_en_o = 1'b1;
                state_nxt        = S_FETCH;
            end
            S_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    ctr_ir_reg_en_o = 1'b1;
                    ctr_pc_reg_en_o = 1'b1;
                    state_nxt       = S_DECODE;
                end else if (wd_expire) begin
                    state_nxt = S_HALT;
                end
            end
            S_DECODE: begin
                state_nxt = S_FETCH_ADR;
                case (opcode_i)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND: begin
                        ctr_marmux_o     = MAR_OP_ARG;
                        ctr_mar_reg_en_o = 1'b1;
                        state_nxt        = S_EXEC_RD;
                    end
                    OP_STA: begin
                        ctr_marmux_o     = MAR_OP_ARG;
                        ctr_mar_reg_en_o = 1'b1;
                        state_nxt        = S_EXEC_WR;
                    end
                    OP_JMP: begin
                        ctr_marmux_o     = MAR_OP_ARG;
                        ctr_mar_reg_en_o = 1'b1;
                        state_nxt        = S_FETCH;
                    end
                    OP_JZ: begin
                        if (acc_zero_i) begin
                            ctr_marmux_o     = MAR_OP_ARG;
                            ctr_mar_reg_en_o = 1'b1;
                            state_nxt        = S_FETCH;
                        end
                    end
                    OP_HLT: begin
                        state_nxt = S_HALT;
                    end
                    default: begin
                        state_nxt = S_FETCH_ADR;
                    end
                endcase
            end
            S_EXEC_RD: begin
                mem_req_o = 1'b1;
                case (op_q)
                    OP_ADD:  ctr_alu_op_o = 2'd1;
                    OP_SUB:  ctr_alu_op_o = 2'd2;
                    OP_AND:  ctr_alu_op_o = 2'd3;
                    default: ctr_alu_op_o = 2'd0;
                endcase
                if (mem_ack_i) begin
                    ctr_acc_reg_en_o = 1'b1;
                    state_nxt        = S_FETCH_ADR;
                end else if (wd_expire) begin
                    state_nxt = S_HALT;
                end
            end
            S_EXEC_WR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                if (mem_ack_i) begin
                    state_nxt = S_FETCH_ADR;
                end else if (wd_expire) begin
                    state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                halted_o = 1'b1;
            end
            default: begin
                state_nxt = S_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_ctl_seq.sv
// Bench for ctl_seq: small memory and address-unit model around the sequencer, a scoreboard
// of expected memory accesses popped by a monitor, plus directed timing/reset/watchdog checks.
module tb_ctl_seq;

    localparam logic MAR_OP_PC  = 1'b0;
    localparam logic MAR_OP_ARG = 1'b1;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [3:0] opcode_i;
    logic       acc_zero_i;
    logic       mem_ack_i;
    logic       ctr_marmux_o;
    logic       ctr_mar_reg_en_o;
    logic       ctr_pc_reg_en_o;
    logic       ctr_ir_reg_en_o;
    logic       ctr_acc_reg_en_o;
    logic [1:0] ctr_alu_op_o;
    logic       mem_req_o;
    logic       mem_we_o;
    logic       halted_o;
    logic       bus_err_o;

    always #5 clk = ~clk;

    ctl_seq #(.ACK_TIMEOUT(4)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .opcode_i         (opcode_i),
        .acc_zero_i       (acc_zero_i),
        .mem_ack_i        (mem_ack_i),
        .ctr_marmux_o     (ctr_marmux_o),
        .ctr_mar_reg_en_o (ctr_mar_reg_en_o),
        .ctr_pc_reg_en_o  (ctr_pc_reg_en_o),
        .ctr_ir_reg_en_o  (ctr_ir_reg_en_o),
        .ctr_acc_reg_en_o (ctr_acc_reg_en_o),
        .ctr_alu_op_o     (ctr_alu_op_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .halted_o         (halted_o),
        .bus_err_o        (bus_err_o)
    );

    // Address unit and instruction memory (ADR_WIDTH = 5, instruction = {opcode, arg}).
    logic [8:0] mem [0:31];
    logic [4:0] mar_m, pc_m;
    logic [8:0] ir_m;
    assign opcode_i = ir_m[8:5];

    always @(posedge clk) begin
        if (rst_i) begin
            mar_m <= '0;
            pc_m  <= '0;
            ir_m  <= '0;
        end else begin
            if (ctr_mar_reg_en_o) mar_m <= (ctr_marmux_o == MAR_OP_ARG) ? ir_m[4:0] : pc_m;
            if (ctr_pc_reg_en_o)  pc_m  <= mar_m + 5'd1;
            if (ctr_ir_reg_en_o)  ir_m  <= mem[mar_m];
        end
    end

    // Ack responder: wait_n wait cycles per access; ack_force drives ack outside the window.
    int   wait_n = 0;
    int   wcnt = 0;
    logic ack_en = 1'b1;
    logic ack_force = 1'b0;

    always @(negedge clk) begin
        if (mem_req_o && ack_en) begin
            if (wcnt >= wait_n) begin
                mem_ack_i = 1'b1;
                wcnt = 0;
            end else begin
                mem_ack_i = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack_i = ack_force;
            wcnt = 0;
        end
    end

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [4:0] ctl;   // {ir_en, pc_en, acc_en, alu_op}
        int         len;
    } xact_t;

    xact_t exp_q[$];
    int    t_done[$];
    int    n_chk = 0;
    int    n_pass = 0;
    int    cyc = 0;
    int    req_len = 0;
    int    acc_pulses = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic push(input logic we, input logic [4:0] a, input logic [4:0] ctl);
        xact_t x;
        x.we = we; x.addr = a; x.ctl = ctl; x.len = wait_n + 1;
        exp_q.push_back(x);
    endtask

    task automatic exp_fetch(input logic [4:0] a);                    push(1'b0, a, 5'b11000);         endtask
    task automatic exp_rd(input logic [4:0] a, input logic [1:0] alu); push(1'b0, a, {3'b001, alu});    endtask
    task automatic exp_wr(input logic [4:0] a);                       push(1'b1, a, 5'b00000);         endtask

    function automatic logic [8:0] ins(input logic [3:0] op, input logic [4:0] a);
        return {op, a};
    endfunction

    // Monitor: samples 1 time unit after the falling edge, pops on each completed access.
    always begin
        xact_t e;
        @(negedge clk);
        #1;
        cyc++;
        if (ctr_acc_reg_en_o) acc_pulses++;
        if (mem_req_o) req_len++;
        if (mem_req_o && mem_ack_i) begin
            t_done.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_access: addr %0d we %0b, expected no access", mar_m, mem_we_o);
            end else begin
                e = exp_q.pop_front();
                chk("xact_addr", 32'(mar_m), 32'(e.addr));
                chk("xact_we", 32'(mem_we_o), 32'(e.we));
                chk("xact_ctl", {ctr_ir_reg_en_o, ctr_pc_reg_en_o, ctr_acc_reg_en_o, ctr_alu_op_o}, 32'(e.ctl));
                chk("xact_req_len", 32'(req_len), 32'(e.len));
            end
            req_len = 0;
        end else if (!mem_req_o) begin
            req_len = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [10:0] out_vec();
        return {ctr_marmux_o, ctr_mar_reg_en_o, ctr_pc_reg_en_o, ctr_ir_reg_en_o, ctr_acc_reg_en_o,
                ctr_alu_op_o, mem_req_o, mem_we_o, halted_o, bus_err_o};
    endfunction

    task automatic wait_halt(input int budget, input string nm);
        int k = 0;
        while (!halted_o && k < budget) begin
            tick();
            k++;
        end
        if (!halted_o) begin
            n_chk++;
            $display("FAIL %s: halted_o still 0 after %0d cycles, expected 1", nm, budget);
        end
    endtask

    task automatic count_req_to_halt(output int nreq);
        nreq = 0;
        for (int k = 0; k < 40 && !halted_o; k++) begin
            if (mem_req_o) nreq++;
            tick();
        end
    endtask

    initial begin
        int nreq;
        rst_i = 1'b1;
        acc_zero_i = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = ins(4'h0, 5'd0);

        // Run A: zero-wait program covering NOP, LDA, STA, ADD, SUB, AND, JMP, JZ not taken, HLT.
        mem[0] = ins(4'h0, 5'd0);
        mem[1] = ins(4'h0, 5'd0);
        mem[2] = ins(4'h0, 5'd0);
        mem[3] = ins(4'h1, 5'h10);
        mem[4] = ins(4'h2, 5'h11);
        mem[5] = ins(4'h3, 5'h12);
        mem[6] = ins(4'h4, 5'h13);
        mem[7] = ins(4'h5, 5'h14);
        mem[8] = ins(4'h6, 5'h1A);
        mem[5'h1A] = ins(4'h7, 5'h05);
        mem[5'h1B] = ins(4'hF, 5'h00);
        exp_fetch(5'd0); exp_fetch(5'd1); exp_fetch(5'd2); exp_fetch(5'd3);
        exp_rd(5'h10, 2'd0); exp_fetch(5'd4); exp_wr(5'h11);
        exp_fetch(5'd5); exp_rd(5'h12, 2'd1);
        exp_fetch(5'd6); exp_rd(5'h13, 2'd2);
        exp_fetch(5'd7); exp_rd(5'h14, 2'd3);
        exp_fetch(5'd8); exp_fetch(5'h1A); exp_fetch(5'h1B);

        tick(); tick(); tick();
        chk("reset_vec", 32'(out_vec()), 32'(0));
        rst_i = 1'b0;
        tick();
        chk("fetch_adr_ctl", {ctr_marmux_o, ctr_mar_reg_en_o, mem_req_o}, {MAR_OP_PC, 1'b1, 1'b0});
        tick();
        chk("first_req", 32'(mem_req_o), 32'(1));
        for (int i = 0; i < 7; i++) tick();
        chk("pc_after_3_nop", 32'(pc_m), 32'(3));
        wait_halt(200, "runA_halt");
        chk("runA_xacts", 32'(t_done.size()), 32'(16));
        if (t_done.size() >= 16) begin
            chk("nop_period_1", 32'(t_done[1] - t_done[0]), 32'(3));
            chk("nop_period_2", 32'(t_done[2] - t_done[1]), 32'(3));
            chk("nop_period_3", 32'(t_done[3] - t_done[2]), 32'(3));
            chk("lda_rd_lat", 32'(t_done[4] - t_done[3]), 32'(2));
            chk("lda_len", 32'(t_done[5] - t_done[3]), 32'(4));
            chk("sta_len", 32'(t_done[7] - t_done[5]), 32'(4));
            chk("jmp_next_fetch", 32'(t_done[14] - t_done[13]), 32'(2));
            chk("jz_nt_len", 32'(t_done[15] - t_done[14]), 32'(3));
        end
        ack_force = 1'b1;
        for (int i = 0; i < 20; i++) begin
            acc_zero_i = 1'($urandom);
            chk("halt_hold", {halted_o, mem_req_o, ctr_mar_reg_en_o, ctr_pc_reg_en_o,
                              ctr_ir_reg_en_o, ctr_acc_reg_en_o, bus_err_o}, 32'b1000000);
            tick();
        end
        ack_force = 1'b0;
        chk("runA_acc_pulses", 32'(acc_pulses), 32'(4));

        // Run B: two wait states, JZ taken to 5, LDA, HLT.
        rst_i = 1'b1;
        tick();
        chk("reset_from_halt", 32'(out_vec()), 32'(0));
        mem[0] = ins(4'h7, 5'h05);
        mem[5] = ins(4'h1, 5'h09);
        mem[6] = ins(4'hF, 5'h00);
        wait_n = 2;
        acc_zero_i = 1'b1;
        t_done.delete();
        exp_fetch(5'd0); exp_fetch(5'd5); exp_rd(5'h09, 2'd0); exp_fetch(5'd6);
        rst_i = 1'b0;
        wait_halt(200, "runB_halt");
        chk("runB_xacts", 32'(t_done.size()), 32'(4));
        if (t_done.size() >= 4) begin
            chk("jz_taken_gap", 32'(t_done[1] - t_done[0]), 32'(4));
            chk("lda_wait_gap", 32'(t_done[2] - t_done[1]), 32'(4));
            chk("after_lda_gap", 32'(t_done[3] - t_done[2]), 32'(4));
        end
        chk("runB_acc_pulses", 32'(acc_pulses), 32'(5));

        // Run C: ack withheld in FETCH, watchdog expires.
        rst_i = 1'b1;
        ack_en = 1'b0;
        wait_n = 0;
        tick(); tick();
        rst_i = 1'b0;
        count_req_to_halt(nreq);
        chk("timeout_req_cycles", 32'(nreq), 32'(5));
        chk("timeout_state", {halted_o, bus_err_o, mem_req_o}, 32'b110);
        tick(); tick(); tick();
        chk("bus_err_sticky", 32'(bus_err_o), 32'(1));

        // Run D: reset during the 3rd wait cycle, then a fresh full timeout.
        rst_i = 1'b1;
        tick();
        chk("bus_err_cleared", 32'(bus_err_o), 32'(0));
        tick();
        rst_i = 1'b0;
        nreq = 0;
        for (int k = 0; k < 20; k++) begin
            if (mem_req_o) nreq++;
            if (nreq == 4) break;
            tick();
        end
        chk("reached_wait3", 32'(nreq), 32'(4));
        rst_i = 1'b1;
        tick();
        chk("reset_mid_handshake", 32'(out_vec()), 32'(0));
        rst_i = 1'b0;
        count_req_to_halt(nreq);
        chk("timeout_after_reset", 32'(nreq), 32'(5));
        chk("timeout_after_reset_state", {halted_o, bus_err_o}, 32'b11);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
